// File: rtl/gate_delay_meter_if.sv
// gate_delay_meter_if: result handshake bus carrying the delay/width measurement.
interface gate_delay_meter_if #(
  parameter int CNT_W = 32
);
  logic             ready;
  logic             valid;
  logic             timeout;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] width;
  modport master (output valid, timeout, delay, width, input ready);
  modport slave  (input valid, timeout, delay, width, output ready);
endinterface

// File: rtl/gate_delay_meter.sv
// gate_delay_meter: measures trigger-to-pulse delay and pulse width in clock cycles.
// Define GDM_OVERRUN_CNT_EN to count triggers ignored while a measurement is pending.
module gate_delay_meter #(
  parameter int               CNT_W   = 32,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(32'hFFFF_FFFE)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_trigger,
  input  logic               i_pulse,
  gate_delay_meter_if.master o_res,
  output logic               o_busy,
  output logic [15:0]        o_overrun
);
  typedef enum logic [1:0] {IDLE, WAIT_PULSE, IN_PULSE, DONE} state_t;
  state_t           r_state, w_state_n;
  logic [1:0]       r_trig_s, r_pulse_s;
  logic             r_trig_l, r_pulse_l;
  logic [CNT_W-1:0] r_cnt, w_cnt_n, r_delay, w_delay_n, r_width, w_width_n;
  logic             r_valid, w_valid_n, r_timeout, w_timeout_n;
  logic             w_trig_ev, w_rise, w_fall, w_to;
  // Both inputs share the same sync depth so their latency cancels in P-T and F-P
  assign w_trig_ev = r_trig_s[1] & ~r_trig_l;
  assign w_rise    = r_pulse_s[1] & ~r_pulse_l;
  assign w_fall    = ~r_pulse_s[1] & r_pulse_l;
  assign w_to      = r_cnt == TIMEOUT;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state   <= IDLE;
      r_trig_s  <= '0;
      r_pulse_s <= '0;
      r_trig_l  <= 1'b0;
      r_pulse_l <= 1'b0;
      r_cnt     <= '0;
      r_delay   <= '0;
      r_width   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_trig_s  <= {r_trig_s[0], i_trigger};
      r_pulse_s <= {r_pulse_s[0], i_pulse};
      r_trig_l  <= r_trig_s[1];
      r_pulse_l <= r_pulse_s[1];
      r_cnt     <= w_cnt_n;
      r_delay   <= w_delay_n;
      r_width   <= w_width_n;
      r_valid   <= w_valid_n;
      r_timeout <= w_timeout_n;
    end
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_delay_n   = r_delay;
    w_width_n   = r_width;
    w_valid_n   = r_valid;
    w_timeout_n = r_timeout;
    case (r_state)
      IDLE: if (w_trig_ev) begin
        w_cnt_n   = CNT_W'(1);
        w_state_n = w_rise ? IN_PULSE : WAIT_PULSE;
        w_delay_n = w_rise ? '0 : r_delay;
      end
      WAIT_PULSE: begin
        w_cnt_n = r_cnt + 1'b1;
        if (w_rise) begin
          w_delay_n = r_cnt;
          w_cnt_n   = CNT_W'(1);
          w_state_n = IN_PULSE;
        end else if (w_to) begin
          w_delay_n   = r_cnt;
          w_width_n   = '0;
          w_timeout_n = 1'b1;
          w_valid_n   = 1'b1;
          w_state_n   = DONE;
        end
      end
      IN_PULSE: begin
        w_cnt_n = r_cnt + 1'b1;
        if (w_fall || w_to) begin
          w_width_n   = r_cnt;
          w_timeout_n = ~w_fall;
          w_valid_n   = 1'b1;
          w_state_n   = DONE;
        end
      end
      default: if (r_valid && o_res.ready) begin
        w_valid_n   = 1'b0;
        w_timeout_n = 1'b0;
        w_state_n   = IDLE;
      end
    endcase
  end
  assign o_busy        = r_state == WAIT_PULSE || r_state == IN_PULSE;
  assign o_res.valid   = r_valid;
  assign o_res.timeout = r_timeout;
  assign o_res.delay   = r_delay;
  assign o_res.width   = r_width;
`ifdef GDM_OVERRUN_CNT_EN
  logic [15:0] r_overrun;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_overrun <= '0;
    else if (w_trig_ev && r_state != IDLE && r_overrun != 16'hFFFF) r_overrun <= r_overrun + 1'b1;
  assign o_overrun = r_overrun;
`else
  assign o_overrun = '0;
`endif
endmodule

// File: tb/tb_gate_delay_meter.sv
// tb_gate_delay_meter: scoreboard bench for gate_delay_meter with TIMEOUT=50.
module tb_gate_delay_meter;
  localparam int CW = 32;
`ifdef GDM_OVERRUN_CNT_EN
  localparam logic [15:0] OVR_INC = 16'd1;
`else
  localparam logic [15:0] OVR_INC = 16'd0;
`endif
  typedef struct {logic [CW-1:0] d; logic [CW-1:0] w; logic t;} exp_t;
  logic        i_clk = 1'b0, i_rst = 1'b1, i_trigger = 1'b0, i_pulse = 1'b0;
  logic        o_busy;
  logic [15:0] o_overrun;
  logic [15:0] exp_ovr = '0;
  int          total = 0, bad = 0;
  exp_t        sb[$];
  gate_delay_meter_if #(.CNT_W(CW)) ifc ();
  gate_delay_meter #(.CNT_W(CW), .TIMEOUT(CW'(50))) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_trigger(i_trigger), .i_pulse(i_pulse),
    .o_res(ifc), .o_busy(o_busy), .o_overrun(o_overrun)
  );
  always #5 i_clk = ~i_clk;
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask
  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      ok = ifc.valid === 1'b1;
      if (!ok) tick(1);
    end
  endtask
  task automatic test_reset();
    i_rst = 1'b1;
    tick(2);
    total++;
    if ({ifc.valid, ifc.timeout, o_busy, ifc.delay, ifc.width, o_overrun} !== '0) begin
      bad++;
      $display("FAIL reset: got v=%b t=%b b=%b d=%0d w=%0d o=%0d need all 0", ifc.valid, ifc.timeout, o_busy, ifc.delay, ifc.width, o_overrun);
    end
    i_rst = 1'b0;
    tick(2);
  endtask
  task automatic test_basic();
    exp_t e;
    ifc.ready = 1'b1;
    i_trigger = 1'b1;
    tick(2);
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_early: got %b need 0", o_busy); end
    tick(1);
    total++;
    if (o_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_start: got %b need 1", o_busy); end
    tick(7);
    i_pulse = 1'b1;
    sb.push_back('{CW'(10), CW'(5), 1'b0});
    tick(5);
    i_pulse = 1'b0;
    i_trigger = 1'b0;
    tick(2);
    total++;
    if ({o_busy, ifc.valid} !== 2'b10) begin bad++; $display("FAIL basic_pre_valid: got busy,valid=%b need 10", {o_busy, ifc.valid}); end
    tick(1);
    total++;
    if ({o_busy, ifc.valid} !== 2'b01) begin bad++; $display("FAIL basic_valid_rise: got busy,valid=%b need 01", {o_busy, ifc.valid}); end
    e = sb.pop_front();
    total++;
    if ({ifc.delay, ifc.width, ifc.timeout} !== {e.d, e.w, e.t}) begin
      bad++;
      $display("FAIL basic_result: got d=%0d w=%0d t=%b need d=%0d w=%0d t=%b", ifc.delay, ifc.width, ifc.timeout, e.d, e.w, e.t);
    end
    tick(1);
    total++;
    if (ifc.valid !== 1'b0) begin bad++; $display("FAIL basic_valid_pulse: got %b need 0", ifc.valid); end
  endtask
  task automatic test_same_cycle();
    exp_t e;
    bit ok;
    i_trigger = 1'b1;
    i_pulse = 1'b1;
    sb.push_back('{CW'(0), CW'(3), 1'b0});
    tick(3);
    i_pulse = 1'b0;
    i_trigger = 1'b0;
    wait_valid(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL same_wait: got no valid need valid"); end
    e = sb.pop_front();
    total++;
    if ({ifc.delay, ifc.width, ifc.timeout} !== {e.d, e.w, e.t}) begin
      bad++;
      $display("FAIL same_result: got d=%0d w=%0d t=%b need d=%0d w=%0d t=%b", ifc.delay, ifc.width, ifc.timeout, e.d, e.w, e.t);
    end
    tick(2);
  endtask
  task automatic test_backpressure();
    exp_t e;
    bit ok;
    ifc.ready = 1'b0;
    i_trigger = 1'b1;
    tick(4);
    i_pulse = 1'b1;
    sb.push_back('{CW'(4), CW'(6), 1'b0});
    tick(6);
    i_pulse = 1'b0;
    wait_valid(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_wait: got no valid need valid"); end
    for (int c = 0; c < 20; c++) begin
      total++;
      if ({ifc.valid, o_busy, ifc.timeout} !== 3'b100 || ifc.delay !== CW'(4) || ifc.width !== CW'(6)) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b b=%b t=%b d=%0d w=%0d need v=1 b=0 t=0 d=4 w=6", c, ifc.valid, o_busy, ifc.timeout, ifc.delay, ifc.width);
      end
      if (c == 3) i_trigger = 1'b0;
      if (c == 8) i_trigger = 1'b1;
      tick(1);
    end
    exp_ovr = exp_ovr + OVR_INC;
    total++;
    if (o_overrun !== exp_ovr) begin bad++; $display("FAIL bp_overrun: got %0d need %0d", o_overrun, exp_ovr); end
    ifc.ready = 1'b1;
    e = sb.pop_front();
    total++;
    if ({ifc.delay, ifc.width, ifc.timeout} !== {e.d, e.w, e.t}) begin
      bad++;
      $display("FAIL bp_result: got d=%0d w=%0d t=%b need d=%0d w=%0d t=%b", ifc.delay, ifc.width, ifc.timeout, e.d, e.w, e.t);
    end
    tick(1);
    total++;
    if ({ifc.valid, o_busy} !== 2'b00) begin bad++; $display("FAIL bp_release: got valid,busy=%b need 00", {ifc.valid, o_busy}); end
    tick(3);
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL bp_ignored: got busy=%b need 0", o_busy); end
    i_trigger = 1'b0;
    tick(3);
  endtask
  task automatic test_timeout();
    exp_t e;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      i_trigger = 1'b1;
      if (k == 0) sb.push_back('{CW'(50), CW'(0), 1'b1});
      else begin
        tick(5);
        i_pulse = 1'b1;
        sb.push_back(k == 1 ? '{CW'(5), CW'(50), 1'b1} : '{CW'(5), CW'(50), 1'b0});
        if (k == 2) begin tick(50); i_pulse = 1'b0; end
      end
      wait_valid(120, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL timeout_wait[%0d]: got no valid need valid", k); end
      e = sb.pop_front();
      total++;
      if ({ifc.delay, ifc.width, ifc.timeout} !== {e.d, e.w, e.t}) begin
        bad++;
        $display("FAIL timeout_result[%0d]: got d=%0d w=%0d t=%b need d=%0d w=%0d t=%b", k, ifc.delay, ifc.width, ifc.timeout, e.d, e.w, e.t);
      end
      tick(1);
      i_trigger = 1'b0;
      i_pulse = 1'b0;
      tick(4);
      total++;
      if ({ifc.valid, o_busy} !== 2'b00) begin bad++; $display("FAIL timeout_idle[%0d]: got valid,busy=%b need 00", k, {ifc.valid, o_busy}); end
    end
  endtask
  task automatic test_prehigh();
    exp_t e;
    bit ok;
    i_pulse = 1'b1;
    tick(4);
    i_trigger = 1'b1;
    tick(4);
    i_pulse = 1'b0;
    tick(16);
    i_pulse = 1'b1;
    sb.push_back('{CW'(20), CW'(8), 1'b0});
    tick(8);
    i_pulse = 1'b0;
    i_trigger = 1'b0;
    wait_valid(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL prehigh_wait: got no valid need valid"); end
    e = sb.pop_front();
    total++;
    if ({ifc.delay, ifc.width, ifc.timeout} !== {e.d, e.w, e.t}) begin
      bad++;
      $display("FAIL prehigh_result: got d=%0d w=%0d t=%b need d=%0d w=%0d t=%b", ifc.delay, ifc.width, ifc.timeout, e.d, e.w, e.t);
    end
    tick(2);
  endtask
  task automatic test_async_reset();
    exp_t e;
    bit ok;
    i_trigger = 1'b1;
    tick(3);
    i_pulse = 1'b1;
    tick(5);
    total++;
    if (o_busy !== 1'b1) begin bad++; $display("FAIL ar_busy: got %b need 1", o_busy); end
    #2 i_rst = 1'b1;
    #1;
    total++;
    if ({ifc.valid, ifc.timeout, o_busy, ifc.delay, ifc.width, o_overrun} !== '0) begin
      bad++;
      $display("FAIL ar_clear: got v=%b t=%b b=%b d=%0d w=%0d o=%0d need all 0", ifc.valid, ifc.timeout, o_busy, ifc.delay, ifc.width, o_overrun);
    end
    i_trigger = 1'b0;
    i_pulse = 1'b0;
    exp_ovr = '0;
    tick(2);
    i_rst = 1'b0;
    tick(3);
    i_trigger = 1'b1;
    tick(7);
    i_pulse = 1'b1;
    sb.push_back('{CW'(7), CW'(2), 1'b0});
    tick(2);
    i_pulse = 1'b0;
    i_trigger = 1'b0;
    wait_valid(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ar_wait: got no valid need valid"); end
    e = sb.pop_front();
    total++;
    if ({ifc.delay, ifc.width, ifc.timeout} !== {e.d, e.w, e.t}) begin
      bad++;
      $display("FAIL ar_result: got d=%0d w=%0d t=%b need d=%0d w=%0d t=%b", ifc.delay, ifc.width, ifc.timeout, e.d, e.w, e.t);
    end
    tick(2);
  endtask
  initial begin
    ifc.ready = 1'b1;
    test_reset();
    test_basic();
    test_same_cycle();
    test_backpressure();
    test_timeout();
    test_prehigh();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gate_delay_meter.md
Name: gate_delay_meter

Overview:
- Measures a gate pulse against a trigger, in clock cycles: the delay from the trigger rising edge to the pulse rising edge, and the pulse width.
- Receive-side companion of the gate/delay pulse generator. Used for loopback self-test of generated gates and for timing characterisation of external gate signals.
- Results are delivered on a valid/ready handshake.

Parameters:
- CNT_W, 32, width of the delay/width counters and result ports.
- TIMEOUT, 32'hFFFF_FFFE, maximum cycles spent in either measuring state before the measurement is aborted (must be < 2^CNT_W − 1).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_trigger  input  1  asynchronous trigger input.
- i_pulse  input  1  asynchronous gate pulse input to be measured.
- i_ready  input  1  consumer accepts the result when high together with o_valid.
- o_delay  output  CNT_W  measured trigger-to-pulse delay in cycles.
- o_width  output  CNT_W  measured pulse width in cycles.
- o_valid  output  1  result available.
- o_timeout  output  1  result was aborted by TIMEOUT; qualified by o_valid.
- o_busy  output  1  measurement in progress (WAIT_PULSE or IN_PULSE).
- o_overrun  output  16  count of ignored triggers (see Optional Feature).

Behaviour:
- Reset: clock i_clk; reset i_rst is asynchronous and active-high. Asserting i_rst clears all registers immediately: state=IDLE, counter=0, o_delay=0, o_width=0, o_valid=0, o_timeout=0, o_busy=0, o_overrun=0, sync flops=0. Reset mid-measurement discards the measurement.
- Synchronisation: i_trigger and i_pulse each pass through a 2-flop synchroniser plus one "last" flop.
  - trig_ev = sync & !last, one cycle wide; pulse_rise and pulse_fall are formed the same way.
  - Both paths have identical latency, so that latency cancels out of the measurements.
- Timing definition: with T, P, F the cycles on which trig_ev, pulse_rise and pulse_fall are asserted: o_delay = P − T and o_width = F − P.
- IDLE:
  - On trig_ev: counter←1, go to WAIT_PULSE.
  - If trig_ev and pulse_rise occur in the same cycle: latch o_delay=0, counter←1, go to IN_PULSE.
  - Pulse edges in IDLE are otherwise ignored.
- WAIT_PULSE (o_busy=1): counter increments each cycle.
  - On pulse_rise: latch o_delay=counter, counter←1, go to IN_PULSE.
  - A pulse already high at T produces no rising edge; the block waits for the next rising edge.
  - Further trig_ev in this state is ignored.
- IN_PULSE (o_busy=1): counter increments each cycle.
  - On pulse_fall: latch o_width=counter, go to DONE.
  - Minimum width is 1.
- Timeout: in WAIT_PULSE or IN_PULSE, when counter==TIMEOUT and the terminating edge is not present that cycle:
  - latch the current counter into the field being measured;
  - force the unmeasured field to 0;
  - set o_timeout=1 and go to DONE.
  - The edge wins if both occur in the same cycle.
- DONE: o_valid=1; o_delay, o_width and o_timeout are held stable.
  - On o_valid & i_ready: o_valid←0, o_timeout←0, go to IDLE.
  - o_delay and o_width keep their last values until the next latch.
  - trig_ev while in DONE is ignored; this includes the accept cycle.
- Latency: o_valid rises on cycle F+1.
- Counter never wraps; the TIMEOUT bound guarantees this.

Optional Feature:
- Macro GDM_OVERRUN_CNT_EN.
- When defined: o_overrun increments on every trig_ev that is ignored (state WAIT_PULSE, IN_PULSE or DONE). It saturates at 16'hFFFF and is cleared only by i_rst.
- When undefined: no counter logic is built and o_overrun is tied to 0.

Test Plan:
- Basic: i_trigger rises at cycle 100, i_pulse rises at 110 and falls at 115, i_ready=1 → o_valid pulses for one cycle, o_delay=10, o_width=5, o_timeout=0; o_busy high from T+1 through F.
- Same-cycle edges: i_trigger and i_pulse rise together, pulse falls 3 cycles later → o_delay=0, o_width=3.
- Backpressure: i_ready=0 for 20 cycles after o_valid rises, with a second trigger during that time → results held stable, second trigger ignored (o_overrun=1 with macro, 0 without); o_valid drops one cycle after i_ready=1.
- Timeout: TIMEOUT=50, trigger with no pulse → o_valid with o_timeout=1, o_delay=50, o_width=0. Repeat with the pulse rising at +5 and never falling → o_delay=5, o_width=50, o_timeout=1.
- Pre-high pulse: i_pulse already high when the trigger rises, falls at +4, rises at +20, falls at +28 → o_delay=20, o_width=8.
- Async reset: assert i_rst mid-IN_PULSE, without a clock edge → all outputs 0 immediately, state IDLE; the next trigger/pulse pair measures correctly.
